// File: rtl/blueberry_pkg.sv
// blueberry_pkg: shared types and constants for the 10-bit datapath control
// sequencer. Holds the opcode, timestep, bus-source and ALU-op encodings, the
// INSTR field positions, the bundled control-output struct and a helper that
// maps an ALU opcode onto its ALU operation code.
package blueberry_pkg;

    typedef enum logic [3:0] {
        OP_LOAD = 4'd0,
        OP_MOV  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_XOR  = 4'd5
    } opcode_t;

    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

    typedef enum logic [1:0] {BUS_NONE, BUS_EXT, BUS_Q0, BUS_G} bus_sel_t;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alu_op_t;

    // INSTR field positions: [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] unused
    localparam int OP_MSB = 9;
    localparam int OP_LSB = 6;
    localparam int RX_MSB = 5;
    localparam int RX_LSB = 4;
    localparam int RY_MSB = 3;
    localparam int RY_LSB = 2;

    typedef struct packed {
        logic     enw;
        logic     enr0;
        logic     enr1;
        logic [1:0] wra;
        logic [1:0] rda0;
        logic [1:0] rda1;
        alu_op_t  alu_op;
        logic     ldg;
        bus_sel_t bus_sel;
        logic     busy;
        logic     done;
        logic     err;
    } ctrl_t;

    // ALU opcodes 2..5 map directly onto ALU ops 0..3
    function automatic alu_op_t alu_op_of(input logic [3:0] op);
        logic [3:0] diff;
        diff = op - 4'd2;
        return alu_op_t'(diff[1:0]);
    endfunction

endpackage

// File: rtl/instr_decode.sv
// instr_decode: purely combinational Moore decode of the sequencer state.
// Ports:
//   ir      - captured instruction register
//   step    - current timestep
//   execute - start request (only meaningful in T0)
//   ctrl    - all register-file / ALU / bus control outputs
//   step_d  - next timestep
module instr_decode
    import blueberry_pkg::*;
(
    input  logic [9:0] ir,
    input  step_t      step,
    input  logic       execute,
    output ctrl_t      ctrl,
    output step_t      step_d
);

    logic [3:0] op;
    logic [1:0] rx;
    logic [1:0] ry;
    logic       unused_low;

    assign op         = ir[OP_MSB:OP_LSB];
    assign rx         = ir[RX_MSB:RX_LSB];
    assign ry         = ir[RY_MSB:RY_LSB];
    assign unused_low = ^ir[1:0];

    always_comb begin
        ctrl      = '0;
        step_d    = step;
        ctrl.busy = (step != T0);
        case (step)
            T0: step_d = execute ? T1 : T0;
            T1: begin
                case (op)
                    OP_LOAD: begin
                        ctrl.bus_sel = BUS_EXT;
                        ctrl.enw     = 1'b1;
                        ctrl.wra     = rx;
                        ctrl.done    = 1'b1;
                        step_d       = T0;
                    end
                    OP_MOV: begin
                        ctrl.enr0 = 1'b1;
                        ctrl.rda0 = ry;
                        step_d    = T2;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
                        ctrl.enr0 = 1'b1;
                        ctrl.rda0 = rx;
                        ctrl.enr1 = 1'b1;
                        ctrl.rda1 = ry;
                        step_d    = T2;
                    end
                    default: begin
                        // invalid opcode: flag and finish without touching the file
                        ctrl.done = 1'b1;
                        ctrl.err  = 1'b1;
                        step_d    = T0;
                    end
                endcase
            end
            T2: begin
                case (op)
                    OP_MOV: begin
                        ctrl.bus_sel = BUS_Q0;
                        ctrl.enw     = 1'b1;
                        ctrl.wra     = rx;
                        ctrl.done    = 1'b1;
                        step_d       = T0;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
                        ctrl.ldg    = 1'b1;
                        ctrl.alu_op = alu_op_of(op);
                        step_d      = T3;
                    end
                    default: step_d = T0;
                endcase
            end
            T3: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
                        ctrl.bus_sel = BUS_G;
                        ctrl.enw     = 1'b1;
                        ctrl.wra     = rx;
                        ctrl.done    = 1'b1;
                    end
                    default: ;
                endcase
                step_d = T0;
            end
            default: step_d = T0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control unit for the 10-bit datapath.
// Captures INSTR on Execute in T0 and steps T1..T3, driving the register file,
// ALU and bus-source controls as Moore decodes of (step, IR).
// Ports:
//   CLKb, RST                - clock (rising edge), async active-high reset
//   INSTR, Execute           - instruction word and start request
//   ENW/ENR0/ENR1, WRA/RDA0/RDA1 - register-file enables and addresses
//   ALU_OP, LDG              - ALU operation and G-register load
//   BUS_SEL                  - bus source for register-file D
//   Busy, Done, Err          - status
module control_sequencer
    import blueberry_pkg::*;
(
    input  logic       CLKb,
    input  logic       RST,
    input  logic [9:0] INSTR,
    input  logic       Execute,
    output logic       ENW,
    output logic       ENR0,
    output logic       ENR1,
    output logic [1:0] WRA,
    output logic [1:0] RDA0,
    output logic [1:0] RDA1,
    output logic [1:0] ALU_OP,
    output logic       LDG,
    output logic [1:0] BUS_SEL,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);

    step_t      step_q, step_d;
    logic [9:0] ir_q, ir_d;
    ctrl_t      ctrl;

    instr_decode u_decode (
        .ir      (ir_q),
        .step    (step_q),
        .execute (Execute),
        .ctrl    (ctrl),
        .step_d  (step_d)
    );

    // IR is only loaded on the T0 -> T1 transition, so INSTR is don't-care while busy
    always_comb begin
        ir_d = ir_q;
        if (step_q == T0 && Execute) ir_d = INSTR;
    end

    always_ff @(posedge CLKb or posedge RST) begin
        if (RST) begin
            step_q <= T0;
            ir_q   <= '0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
        end
    end

    assign ENW     = ctrl.enw;
    assign ENR0    = ctrl.enr0;
    assign ENR1    = ctrl.enr1;
    assign WRA     = ctrl.wra;
    assign RDA0    = ctrl.rda0;
    assign RDA1    = ctrl.rda1;
    assign ALU_OP  = ctrl.alu_op;
    assign LDG     = ctrl.ldg;
    assign BUS_SEL = ctrl.bus_sel;
    assign Busy    = ctrl.busy;
    assign Done    = ctrl.done;
    assign Err     = ctrl.err;

endmodule
